alu_sequencer: RTL and testbench
================================

# alu_sequencer

Command sequencer for the binary calculator. It accepts a three-word command stream (operand A, operand B, operation select) over a valid/ready input channel. It drives the combinational ALU, registers the ALU result, and keeps only the flag bits that mean something for the selected operation. The result goes out on a valid/ready output channel. The block sits between the operand source (keypad/UART front end) and the display/result consumer, and is the only driver of the ALU inputs.

## Interface
- INBITS, 8, operand/result width; must be ≥ 4.

- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- clr  input  1  synchronous abort; returns to LOAD_A, drops any pending result
- in_valid  input  1  in_data holds a command word
- in_ready  output  1  sequencer accepts a command word this cycle
- in_data  input  INBITS  command word: A, then B, then op (op in bits [3:0], upper bits ignored)
- alu_A  output  INBITS  ALU operand A (registered)
- alu_B  output  INBITS  ALU operand B (registered)
- alu_Sel  output  4  ALU operation select (registered)
- alu_Out  input  INBITS  ALU result
- alu_Flag  input  4  ALU flags: [0] zero, [1] carry, [2] multiply overflow, [3] borrow/less-than
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts result
- res_out  output  INBITS  registered result
- res_flag  output  4  registered, masked flags
- res_err  output  1  op code was unsupported (≥ 4'hC)
- op_count  output  8  count of delivered results, wraps

## Operation
- States: LOAD_A, LOAD_B, LOAD_OP, EXEC, DONE. Reset state is LOAD_A.
- in_ready = 1 in LOAD_A, LOAD_B and LOAD_OP. It is 0 in EXEC and DONE, and 0 while rst is high.
- LOAD_A: on in_valid & in_ready, alu_A ← in_data, go to LOAD_B.
- LOAD_B: on handshake, alu_B ← in_data, go to LOAD_OP.
- LOAD_OP: on handshake, alu_Sel ← in_data[3:0], go to EXEC.
- EXEC, one cycle:
  - res_out ← alu_Out.
  - res_flag ← alu_Flag & mask(alu_Sel).
  - res_err ← (alu_Sel ≥ 4'hC).
  - Go to DONE.
- Flag mask by alu_Sel:
  - 0: 4'b0011
  - 1, 3: 4'b1001
  - 2: 4'b0101
  - 4–B: 4'b0001
  - ≥ C: 4'b0000, and res_out is forced to 0.
- DONE: res_valid = 1. On res_ready, go to LOAD_A and increment op_count by 1 (mod 256).
- alu_A, alu_B and alu_Sel hold their values until overwritten by the next load. The ALU inputs are therefore stable for the whole EXEC cycle.
- clr takes priority over every transition and handshake in the same cycle:
  - state ← LOAD_A, res_valid drops.
  - op_count is not incremented, even if res_ready is high that cycle.
  - ALU input registers and result registers keep their values.
- in_valid is ignored in EXEC and DONE. No word is consumed there.

## Timing
- Reset values:
  - in_ready 0 while rst is high, 1 the cycle after release.
  - alu_A 0, alu_B 0, alu_Sel 4'hF.
  - res_valid 0, res_out 0, res_flag 0, res_err 0, op_count 0.
- rst may assert in any state, including mid-command or with res_valid high. All state and outputs return to reset values immediately (asynchronously). A partially loaded command is discarded.
- Latency: with the op-word handshake at edge k, EXEC occupies cycle k..k+1 and res_valid is high after edge k+1.
- res_out, res_flag and res_err are stable while res_valid is high.
- Minimum period is 5 cycles per operation: 3 loads + EXEC + DONE, with in_valid and res_ready held high.
- Back-pressure: res_valid holds indefinitely while res_ready is low. in_ready stays 0 during that time.
- The ALU path is combinational. alu_Out and alu_Flag must settle within one cycle of alu_A, alu_B and alu_Sel changing.

## Test plan
- Reset mid-DONE (res_valid = 1, op_count = 3), assert rst asynchronously between edges -> all outputs at reset values immediately; after release in_ready = 1, op_count = 0.
- Words 200, 100, 0 (add), res_ready high -> res_out = 8'd44, res_flag = 4'b0010, res_err = 0, res_valid exactly 1 cycle, op_count = 1.
- Words 5, 7, 1 (subtract) -> res_out = 8'hFE, res_flag = 4'b1000. Then words 16, 16, 2 (multiply) -> res_out = 0, res_flag = 4'b0101.
- Words 3, 3, 4'hC -> res_out = 0, res_flag = 0, res_err = 1. Then words 3, 3, 4'h6 -> res_out = 3, res_err = 0.
- Back-pressure and abort:
  - Hold res_ready low 10 cycles -> res_valid, res_out and res_flag stable; in_ready = 0; in_valid pulses not consumed.
  - Assert clr in LOAD_B -> next accepted word lands in alu_A.
  - Assert clr with res_ready high in DONE -> op_count unchanged.
- Run 257 back-to-back operations with in_valid and res_ready held high -> op_count wraps to 1; each operation takes exactly 5 cycles.

Source files
------------

// File: rtl/alu_sequencer.sv
// Command sequencer for the binary calculator: loads A, B and op words, drives the
// combinational ALU, captures its masked result and offers it on a valid/ready channel.
module alu_sequencer #(
  parameter int INBITS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INBITS-1:0] in_data,
  output logic [INBITS-1:0] alu_A,
  output logic [INBITS-1:0] alu_B,
  output logic [3:0]        alu_Sel,
  input  logic [INBITS-1:0] alu_Out,
  input  logic [3:0]        alu_Flag,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [INBITS-1:0] res_out,
  output logic [3:0]        res_flag,
  output logic              res_err,
  output logic [7:0]        op_count
);

  typedef enum logic [2:0] {
    LOAD_A,
    LOAD_B,
    LOAD_OP,
    EXEC,
    DONE
  } state_t;

  state_t     state;
  logic       in_fire;
  logic       sel_err;
  logic [3:0] flag_mask;

  assign in_fire = in_valid & in_ready;
  assign sel_err = (alu_Sel >= 4'hC);

  // Only flags that carry meaning for the selected operation survive to the result.
  always_comb begin
    flag_mask = 4'b0000;
    case (alu_Sel)
      4'h0:        flag_mask = 4'b0011;
      4'h1, 4'h3:  flag_mask = 4'b1001;
      4'h2:        flag_mask = 4'b0101;
      4'h4, 4'h5, 4'h6, 4'h7,
      4'h8, 4'h9, 4'hA, 4'hB:
                   flag_mask = 4'b0001;
      default:     flag_mask = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOAD_A;
      in_ready  <= 1'b0;
      alu_A     <= '0;
      alu_B     <= '0;
      alu_Sel   <= 4'hF;
      res_valid <= 1'b0;
      res_out   <= '0;
      res_flag  <= 4'b0000;
      res_err   <= 1'b0;
      op_count  <= 8'd0;
    end else if (clr) begin
      state     <= LOAD_A;
      in_ready  <= 1'b1;
      res_valid <= 1'b0;
    end else begin
      case (state)
        LOAD_A: begin
          in_ready <= 1'b1;
          if (in_fire) begin
            alu_A <= in_data;
            state <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (in_fire) begin
            alu_B <= in_data;
            state <= LOAD_OP;
          end
        end
        LOAD_OP: begin
          if (in_fire) begin
            alu_Sel  <= in_data[3:0];
            in_ready <= 1'b0;
            state    <= EXEC;
          end
        end
        EXEC: begin
          // Unsupported ops report an error with a zero result and no flags.
          res_out   <= sel_err ? '0 : alu_Out;
          res_flag  <= alu_Flag & flag_mask;
          res_err   <= sel_err;
          res_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            in_ready  <= 1'b1;
            op_count  <= op_count + 8'd1;
            state     <= LOAD_A;
          end
        end
        default: begin
          state     <= LOAD_A;
          in_ready  <= 1'b1;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed scoreboard bench for alu_sequencer with a behavioural ALU attached to its ALU port.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [7:0] alu_A;
  logic [7:0] alu_B;
  logic [3:0] alu_Sel;
  logic [7:0] alu_Out;
  logic [3:0] alu_Flag;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_out;
  logic [3:0] res_flag;
  logic       res_err;
  logic [7:0] op_count;

  typedef struct packed {
    logic [7:0] out;
    logic [3:0] flag;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;
  int   cyc    = 0;

  alu_sequencer #(.INBITS(8)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .alu_A(alu_A), .alu_B(alu_B), .alu_Sel(alu_Sel),
    .alu_Out(alu_Out), .alu_Flag(alu_Flag),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_out(res_out), .res_flag(res_flag), .res_err(res_err),
    .op_count(op_count)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Raw ALU: every flag is always computed so the sequencer's masking is exercised.
  function automatic logic [11:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] sel);
    logic [8:0]  sum;
    logic [15:0] prod;
    logic [7:0]  o;
    sum  = {1'b0, a} + {1'b0, b};
    prod = a * b;
    case (sel)
      4'h0:       o = sum[7:0];
      4'h1, 4'h3: o = a - b;
      4'h2:       o = prod[7:0];
      4'h4:       o = a & b;
      4'h5:       o = a | b;
      4'h6:       o = a;
      4'h7:       o = b;
      4'h8:       o = ~a;
      4'h9:       o = a << 1;
      4'hA:       o = a >> 1;
      4'hB:       o = a ^ b;
      default:    o = a;
    endcase
    return {(a < b), (prod[15:8] != 8'd0), sum[8], (o == 8'd0), o};
  endfunction

  always_comb {alu_Flag, alu_Out} = alu_fn(alu_A, alu_B, alu_Sel);

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic [3:0] op);
    logic [11:0] r;
    exp_t        e;
    r = alu_fn(a, b, op);
    e.err = (op >= 4'hC);
    e.out = e.err ? 8'd0 : r[7:0];
    case (op)
      4'h0:       e.flag = r[11:8] & 4'b0011;
      4'h1, 4'h3: e.flag = r[11:8] & 4'b1001;
      4'h2:       e.flag = r[11:8] & 4'b0101;
      default:    e.flag = e.err ? 4'b0000 : (r[11:8] & 4'b0001);
    endcase
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  // Presents one word and returns at the falling edge after it was accepted.
  task automatic sendWord(input logic [7:0] w);
    int n;
    in_valid = 1'b1;
    in_data  = w;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("handshake", {31'd0, in_ready}, 32'd1);
    if (in_ready) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic [3:0] op, input bit keep);
    sendWord(a);
    sendWord(b);
    sb.push_back(model(a, b, op));
    sendWord({4'hA, op});
    in_valid = keep;
  endtask

  task automatic checkOutput(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (!res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
    if (sb.size() == 0) e = '0;
    else e = sb.pop_front();
    chk({tag, "_out"},  {24'd0, res_out},  {24'd0, e.out});
    chk({tag, "_flag"}, {28'd0, res_flag}, {28'd0, e.flag});
    chk({tag, "_err"},  {31'd0, res_err},  {31'd0, e.err});
  endtask

  initial begin
    int prev_t;
    int bad;
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = 8'd0; res_ready = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_sel",      {28'd0, alu_Sel},  32'hF);
    chk("rst_valid",    {31'd0, res_valid}, 32'd0);
    chk("rst_count",    {24'd0, op_count}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // Basic operations with the consumer always ready.
    res_ready = 1'b1;
    applyStimulus(8'd200, 8'd100, 4'h0, 1'b0);
    checkOutput("add");
    chk("add_out_lit",  {24'd0, res_out},  32'd44);
    chk("add_flag_lit", {28'd0, res_flag}, 32'b0010);
    @(negedge clk);
    chk("add_one_cycle", {31'd0, res_valid}, 32'd0);
    chk("add_count",     {24'd0, op_count}, 32'd1);
    applyStimulus(8'd5, 8'd7, 4'h1, 1'b0);
    checkOutput("sub");
    chk("sub_out_lit", {24'd0, res_out}, 32'hFE);
    applyStimulus(8'd16, 8'd16, 4'h2, 1'b0);
    checkOutput("mul");
    chk("mul_flag_lit", {28'd0, res_flag}, 32'b0101);
    applyStimulus(8'd3, 8'd3, 4'hC, 1'b0);
    checkOutput("bad_op");
    applyStimulus(8'd3, 8'd3, 4'h6, 1'b0);
    checkOutput("pass_a");
    chk("pass_a_lit", {24'd0, res_out}, 32'd3);
    @(negedge clk);
    chk("count5", {24'd0, op_count}, 32'd5);

    // Back-pressure: result must hold and input words must be refused.
    res_ready = 1'b0;
    applyStimulus(8'd4, 8'd9, 4'h1, 1'b0);
    checkOutput("bp");
    for (int i = 0; i < 10; i++) begin
      in_valid = ~in_valid;
      in_data  = 8'h55;
      @(negedge clk);
      chk("bp_hold_valid", {31'd0, res_valid}, 32'd1);
      chk("bp_hold_out",   {24'd0, res_out},  32'hFB);
      chk("bp_hold_flag",  {28'd0, res_flag}, 32'b1000);
      chk("bp_in_ready",   {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    chk("bp_a_kept", {24'd0, alu_A}, 32'd4);
    chk("bp_b_kept", {24'd0, alu_B}, 32'd9);
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", {31'd0, res_valid}, 32'd0);
    chk("bp_count",   {24'd0, op_count}, 32'd6);

    // Abort in LOAD_B: the next word must restart at operand A.
    sendWord(8'd11);
    in_valid = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    sendWord(8'd22);
    in_valid = 1'b0;
    chk("clr_b_a", {24'd0, alu_A}, 32'd22);
    chk("clr_b_b", {24'd0, alu_B}, 32'd9);
    sendWord(8'd33);
    sb.push_back(model(8'd22, 8'd33, 4'h0));
    sendWord(8'h00);
    in_valid = 1'b0;
    checkOutput("clr_b");
    @(negedge clk);
    chk("clr_b_count", {24'd0, op_count}, 32'd7);

    // Abort in DONE with res_ready high: no delivery is counted.
    res_ready = 1'b0;
    applyStimulus(8'd1, 8'd2, 4'h0, 1'b0);
    checkOutput("clr_done");
    clr = 1'b1;
    res_ready = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    res_ready = 1'b0;
    chk("clr_done_valid", {31'd0, res_valid}, 32'd0);
    chk("clr_done_count", {24'd0, op_count}, 32'd7);
    chk("clr_done_ready", {31'd0, in_ready}, 32'd1);
    chk("clr_done_out",   {24'd0, res_out},  32'd3);

    // Asynchronous reset while a result is pending.
    applyStimulus(8'd200, 8'd100, 4'h0, 1'b0);
    checkOutput("pre_rst");
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, res_valid}, 32'd0);
    chk("arst_out",   {24'd0, res_out},  32'd0);
    chk("arst_flag",  {28'd0, res_flag}, 32'd0);
    chk("arst_ready", {31'd0, in_ready}, 32'd0);
    chk("arst_a",     {24'd0, alu_A},    32'd0);
    chk("arst_sel",   {28'd0, alu_Sel},  32'hF);
    chk("arst_count", {24'd0, op_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_rel_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_rel_count", {24'd0, op_count}, 32'd0);

    // Back-to-back operations: 5 cycles each and op_count wraps past 255.
    res_ready = 1'b1;
    bad = 0;
    prev_t = 0;
    for (int i = 0; i < 257; i++) begin
      logic [7:0] a;
      logic [7:0] b;
      logic [3:0] op;
      a  = 8'(i);
      b  = 8'(i) ^ 8'h5A;
      op = 4'(i % 16);
      sendWord(a);
      if (i > 0 && (cyc - prev_t) != 5) bad++;
      prev_t = cyc;
      sendWord(b);
      sb.push_back(model(a, b, op));
      sendWord({4'h5, op});
      checkOutput("b2b");
    end
    in_valid = 1'b0;
    chk("b2b_period", bad, 32'd0);
    @(negedge clk);
    chk("b2b_wrap", {24'd0, op_count}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
